// File: rtl/board_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : board_checker
//  Description : Tic-tac-toe board store with a one-line-per-cycle win/draw
//                scanner and a combinational display read port.
//  Revision    : 1.0  initial release
// ============================================================================
module board_checker (
   input  logic       ph1,
   input  logic       reset,
   input  logic       boardWrite,
   input  logic [3:0] addr,
   input  logic [1:0] cellState,
   input  logic [3:0] readAddr,
   output logic [1:0] readState,
   output logic       busy,
   output logic       gameIsDone,
   output logic [1:0] winner,
   output logic       isDraw,
   output logic [2:0] winLine,
   output logic       writeError
);

   localparam logic [1:0] C_EMPTY = 2'b00;
   localparam logic [1:0] C_X     = 2'b10;
   localparam logic [1:0] C_O     = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [8:0][1:0] board_q, board_d;
   logic [3:0]      filled_q, filled_d;
   logic [2:0]      line_q, line_d;
   logic            armed_q, armed_d;
   logic [1:0]      winner_q, winner_d;
   logic            isDraw_q, isDraw_d;
   logic [2:0]      winLine_q, winLine_d;
   logic            done_q, done_d;
   logic            werr_q, werr_d;

   logic [3:0]      idx0_w, idx1_w, idx2_w;
   logic [1:0]      c0_w, c1_w, c2_w;
   logic            match_w;
   logic [1:0]      target_w;
   logic            markOk_w;

   // Cell lookup that returns EMPTY for any address beyond the board.
   function automatic logic [1:0] cell_at(input logic [8:0][1:0] b, input logic [3:0] idx);
      cell_at = C_EMPTY;
      for (int i = 0; i < 9; i++) begin
         if (idx == 4'(i)) cell_at = b[i];
      end
   endfunction

   // Map the current line counter onto its three board cells.
   always_comb begin
      idx0_w = 4'd0;
      idx1_w = 4'd1;
      idx2_w = 4'd2;
      case (line_q)
         3'd0: begin idx0_w = 4'd0; idx1_w = 4'd1; idx2_w = 4'd2; end
         3'd1: begin idx0_w = 4'd3; idx1_w = 4'd4; idx2_w = 4'd5; end
         3'd2: begin idx0_w = 4'd6; idx1_w = 4'd7; idx2_w = 4'd8; end
         3'd3: begin idx0_w = 4'd0; idx1_w = 4'd3; idx2_w = 4'd6; end
         3'd4: begin idx0_w = 4'd1; idx1_w = 4'd4; idx2_w = 4'd7; end
         3'd5: begin idx0_w = 4'd2; idx1_w = 4'd5; idx2_w = 4'd8; end
         3'd6: begin idx0_w = 4'd0; idx1_w = 4'd4; idx2_w = 4'd8; end
         default: begin idx0_w = 4'd2; idx1_w = 4'd4; idx2_w = 4'd6; end
      endcase
   end

   assign c0_w     = cell_at(board_q, idx0_w);
   assign c1_w     = cell_at(board_q, idx1_w);
   assign c2_w     = cell_at(board_q, idx2_w);
   assign match_w  = (c0_w != C_EMPTY) && (c0_w == c1_w) && (c1_w == c2_w);
   assign target_w = cell_at(board_q, addr);
   assign markOk_w = (cellState == C_X) || (cellState == C_O);

   // Next-state logic: move acceptance, line scan and result capture.
   // The first CHECK cycle only arms the scanner, so line k resolves at the
   // (k+2)th edge after the accepting edge.
   always_comb begin
      state_d   = state_q;
      board_d   = board_q;
      filled_d  = filled_q;
      line_d    = line_q;
      armed_d   = armed_q;
      winner_d  = winner_q;
      isDraw_d  = isDraw_q;
      winLine_d = winLine_q;
      done_d    = done_q;
      werr_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (boardWrite) begin
               if ((addr <= 4'd8) && (target_w == C_EMPTY) && markOk_w) begin
                  for (int i = 0; i < 9; i++) begin
                     if (addr == 4'(i)) board_d[i] = cellState;
                  end
                  filled_d = filled_q + 4'd1;
                  line_d   = 3'd0;
                  armed_d  = 1'b0;
                  state_d  = S_CHECK;
               end else begin
                  werr_d = 1'b1;
               end
            end
         end
         S_CHECK: begin
            if (boardWrite) werr_d = 1'b1;
            if (!armed_q) begin
               armed_d = 1'b1;
            end else if (match_w) begin
               winner_d  = c0_w;
               winLine_d = line_q;
               done_d    = 1'b1;
               state_d   = S_DONE;
            end else if (line_q == 3'd7) begin
               if (filled_q == 4'd9) begin
                  isDraw_d = 1'b1;
                  done_d   = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               line_d = line_q + 3'd1;
            end
         end
         S_DONE: begin
            if (boardWrite) werr_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register with synchronous reset taking priority over any strobe.
   always_ff @(posedge ph1) begin
      if (reset) begin
         state_q   <= S_IDLE;
         board_q   <= '0;
         filled_q  <= 4'd0;
         line_q    <= 3'd0;
         armed_q   <= 1'b0;
         winner_q  <= C_EMPTY;
         isDraw_q  <= 1'b0;
         winLine_q <= 3'd0;
         done_q    <= 1'b0;
         werr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         board_q   <= board_d;
         filled_q  <= filled_d;
         line_q    <= line_d;
         armed_q   <= armed_d;
         winner_q  <= winner_d;
         isDraw_q  <= isDraw_d;
         winLine_q <= winLine_d;
         done_q    <= done_d;
         werr_q    <= werr_d;
      end
   end

   assign readState  = cell_at(board_q, readAddr);
   assign busy       = (state_q == S_CHECK);
   assign gameIsDone = done_q;
   assign winner     = winner_q;
   assign isDraw     = isDraw_q;
   assign winLine    = winLine_q;
   assign writeError = werr_q;

endmodule
`default_nettype wire
